// File: rtl/router_pkg.sv
// Shared router types: default flit width and the RTPort transmit FSM encoding.
package router_pkg;
  localparam int RT_DEFAULT_WIDTH = 512;

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_RELEASE} rt_tx_state_t;
endpackage

// File: rtl/rt_fifo.sv
// Synchronous FIFO, head always presented; push while full / pop while empty are ignored.
module rt_fifo
  import router_pkg::*;
#(
  parameter int WIDTH = RT_DEFAULT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Storage is not reset: occupancy is tracked solely by count/pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/rt_port_tx.sv
// RTPort transmitter: buffers flits and sends each with a 4-phase req/ack handshake.
module rt_port_tx
  import router_pkg::*;
#(
  parameter int WIDTH    = RT_DEFAULT_WIDTH,
  parameter int DEPTH    = 4,
  parameter int ACK_SYNC = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     tx_req,
  output logic [WIDTH-1:0]         tx_data,
  input  logic                     tx_ack,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [31:0]              sent_count,
  output logic                     protocol_err
);
  rt_tx_state_t     state, state_n;
  logic [WIDTH-1:0] head;
  logic             full, empty;
  logic             load, sent_inc, err_set;
  logic [1:0]       ack_pipe;
  logic             ack_s;

  assign in_ready = !full;

  rt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .din   (in_data),
    .pop   (load),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) ack_pipe <= '0;
    else     ack_pipe <= {ack_pipe[0], tx_ack};
  end

  assign ack_s = (ACK_SYNC != 0) ? ack_pipe[1] : tx_ack;

  always_ff @(posedge clk) begin
    if (rst) state <= TX_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    sent_inc = 1'b0;
    err_set  = 1'b0;
    case (state)
      // A stale ack from the receiver blocks launch until it clears.
      TX_IDLE: begin
        if (ack_s) err_set = 1'b1;
        else if (!empty) begin
          load    = 1'b1;
          state_n = TX_REQ;
        end
      end
      TX_REQ: begin
        if (ack_s) begin
          sent_inc = 1'b1;
          state_n  = TX_RELEASE;
        end
      end
      TX_RELEASE: begin
        if (!ack_s) begin
          if (!empty) begin
            load    = 1'b1;
            state_n = TX_REQ;
          end else begin
            state_n = TX_IDLE;
          end
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

  // tx_data is only reloaded on the edge that raises tx_req.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_req       <= 1'b0;
      tx_data      <= '0;
      sent_count   <= '0;
      protocol_err <= 1'b0;
    end else begin
      tx_req <= (state_n == TX_REQ);
      if (load)     tx_data      <= head;
      if (sent_inc) sent_count   <= sent_count + 32'd1;
      if (err_set)  protocol_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rt_port_tx.sv
// Randomized scoreboard bench for rt_port_tx (direct-ack and synchronised-ack instances).
module tb_rt_port_tx;
  localparam int W = 64;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, tx_req, tx_ack, protocol_err;
  logic [W-1:0] in_data, tx_data;
  logic [2:0]   fifo_count;
  logic [31:0]  sent_count;

  logic         s_in_valid, s_in_ready, s_tx_req, s_tx_ack, s_protocol_err;
  logic [W-1:0] s_in_data, s_tx_data;
  logic [2:0]   s_fifo_count;
  logic [31:0]  s_sent_count;

  rt_port_tx #(.WIDTH(W), .DEPTH(D), .ACK_SYNC(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack), .fifo_count(fifo_count),
    .sent_count(sent_count), .protocol_err(protocol_err)
  );

  rt_port_tx #(.WIDTH(W), .DEPTH(D), .ACK_SYNC(1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .tx_req(s_tx_req), .tx_data(s_tx_data), .tx_ack(s_tx_ack), .fifo_count(s_fifo_count),
    .sent_count(s_sent_count), .protocol_err(s_protocol_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Receiver model: ack follows req one cycle late; can be forced, held low or randomly slowed.
  bit   force_ack = 0, hold_ack = 0, rand_ack = 0;
  logic req_d = 0, s_req_d = 0;
  always @(negedge clk) begin
    if (force_ack)     tx_ack = 1'b1;
    else if (hold_ack) tx_ack = 1'b0;
    else if (!rand_ack || ($urandom_range(1, 0) == 1)) tx_ack = req_d;
    req_d    = tx_req;
    s_tx_ack = s_req_d;
    s_req_d  = s_tx_req;
  end

  // Scoreboard monitor: each req rise pops one expected flit; each req fall is one completed send.
  logic [W-1:0] exp_q[$];
  int           model_sent = 0;
  logic         prev_req   = 0;
  logic [W-1:0] prev_data  = '0;
  int           cyc = 0, last_rise = 0;
  bit           b2b_mode = 0, have_last = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      exp_q.delete();
      model_sent = 0;
      prev_req   = 0;
      prev_data  = '0;
      have_last  = 0;
    end else begin
      if (tx_req && !prev_req) begin
        if (exp_q.size() == 0) chk("unexpected_req", 1, 0);
        else                   chk("tx_data_order", tx_data, exp_q.pop_front());
        if (b2b_mode) begin
          if (have_last) chk("b2b_period", cyc - last_rise, 4);
          last_rise = cyc;
          have_last = 1;
        end
      end else if (tx_req || tx_ack) begin
        chk("tx_data_stable", tx_data, prev_data);
      end
      if (!tx_req && prev_req) begin
        model_sent++;
        chk("sent_count", sent_count, model_sent);
      end
      prev_req  = tx_req;
      prev_data = tx_data;
    end
  end

  // Called at a negedge; returns at the negedge after the flit was accepted.
  task automatic push(input logic [W-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", 1, 0);
    else           exp_q.push_back(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((tx_req || tx_ack || fifo_count != 0 || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("wait_idle_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, n;
    logic [W-1:0] d;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; s_in_valid = 1'b0; s_in_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_sent_count", sent_count, 0);
    chk("rst_protocol_err", protocol_err, 0);
    chk("rst_in_ready", in_ready, 1);

    // Single flit: req rises on the second edge after the push, held two cycles.
    push(64'hA5);
    chk("latency_early", tx_req, 0);
    @(negedge clk);
    chk("latency_req", tx_req, 1);
    chk("single_data", tx_data, 64'hA5);
    hi = 0;
    while (tx_req && hi < 50) begin hi++; @(negedge clk); end
    chk("req_high_direct", hi, 2);
    wait_idle();
    chk("single_sent", sent_count, 1);

    // Fill and backpressure
    hold_ack = 1;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) push(W'(i));
    chk("fill_count", fifo_count, 4);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_tx_data", tx_data, 1);
    in_valid = 1'b1; in_data = 64'h99;
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_refused", fifo_count, 4);
    hold_ack = 0;
    wait_idle();
    chk("fill_sent", sent_count, 6);

    // Back-to-back random flits
    have_last = 0;
    b2b_mode  = 1;
    for (int i = 0; i < 8; i++) push({$urandom, $urandom});
    wait_idle();
    b2b_mode = 0;
    chk("b2b_sent", sent_count, 14);

    // Protocol error: ack high while idle blocks the launch
    force_ack = 1;
    repeat (2) @(negedge clk);
    push({$urandom, $urandom});
    repeat (3) @(negedge clk);
    chk("perr_req_blocked", tx_req, 0);
    chk("perr_set", protocol_err, 1);
    chk("perr_fifo", fifo_count, 1);
    force_ack = 0;
    wait_idle();
    chk("perr_sticky", protocol_err, 1);
    chk("perr_sent", sent_count, 15);

    // Random gaps with a randomly slow receiver
    rand_ack = 1;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(3, 0)) @(negedge clk);
      push({$urandom, $urandom});
    end
    wait_idle();
    rand_ack = 0;
    chk("rand_sent", sent_count, 35);

    // Reset while in REQ with three flits buffered
    hold_ack = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push({$urandom, $urandom});
    @(negedge clk);
    chk("pre_rst_req", tx_req, 1);
    chk("pre_rst_count", fifo_count, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_req", tx_req, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_sent", sent_count, 0);
    chk("mid_rst_perr", protocol_err, 0);
    hold_ack = 0;
    repeat (2) @(negedge clk);
    push({$urandom, $urandom});
    wait_idle();
    chk("post_rst_sent", sent_count, 1);

    // Synchronised ack: req held two cycles longer
    s_in_valid = 1'b1; s_in_data = 64'h5A;
    @(negedge clk);
    s_in_valid = 1'b0;
    n = 0;
    while (!s_tx_req && n < 20) begin @(negedge clk); n++; end
    chk("sync_latency", n, 1);
    chk("sync_data", s_tx_data, 64'h5A);
    hi = 0;
    while (s_tx_req && hi < 50) begin hi++; @(negedge clk); end
    chk("req_high_sync", hi, 4);
    n = 0;
    while ((s_tx_req || s_tx_ack) && n < 50) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    chk("sync_sent", s_sent_count, 1);
    chk("sync_req_idle", s_tx_req, 0);
    chk("sync_perr", s_protocol_err, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
